// File: rtl/twiddle_mult_pkg.sv
// Shared FFT definitions: twiddle fixed-point format and exponent stride,
// plus the elaboration-time coefficient generator used by every stage's ROM.
package twiddle_mult_pkg;

    localparam real TW_PI = 3.14159265358979323846;

    function automatic int tw_unity(input int tw_w);
        return 1 << (tw_w - 2);
    endfunction

    function automatic int tw_stride(input int fft_n, input int stage_l);
        return fft_n / stage_l;
    endfunction

    function automatic int tw_round(input real x);
        if (x >= 0.0)
            return $rtoi(x + 0.5);
        else
            return -$rtoi(-x + 0.5);
    endfunction

    // imag=0 gives cos term, imag=1 gives -sin term of W(e)
    function automatic int tw_coef(input int e, input int fft_n, input int tw_w, input bit imag);
        real ang;
        real v;
        ang = 2.0 * TW_PI * real'(e) / real'(fft_n);
        v   = imag ? -$sin(ang) : $cos(ang);
        return tw_round(v * real'(tw_unity(tw_w)));
    endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Twiddle ROM: FFT_N/2 {wr, wi} entries built at elaboration, registered read.
module twiddle_rom
    import twiddle_mult_pkg::*;
#(
    parameter int  FFT_N = 64,
    parameter int  TW_W  = 16,
    localparam int DEPTH = FFT_N / 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   mclk,
    input  logic [AW-1:0]          i_addr,
    output logic signed [TW_W-1:0] o_wr,
    output logic signed [TW_W-1:0] o_wi
);

    logic signed [TW_W-1:0] rom_re [DEPTH];
    logic signed [TW_W-1:0] rom_im [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam int WR = tw_coef(k, FFT_N, TW_W, 1'b0);
        localparam int WI = tw_coef(k, FFT_N, TW_W, 1'b1);
        assign rom_re[k] = TW_W'(WR);
        assign rom_im[k] = TW_W'(WI);
    end

    logic signed [TW_W-1:0] wr_d, wr_q;
    logic signed [TW_W-1:0] wi_d, wi_q;

    always_comb begin
        wr_d = rom_re[i_addr];
        wi_d = rom_im[i_addr];
    end

    always_ff @(posedge mclk) begin
        wr_q <= wr_d;
        wi_q <= wi_d;
    end

    assign o_wr = wr_q;
    assign o_wi = wi_q;

endmodule

// File: rtl/twiddle_mult.sv
// FFT stage twiddle multiplier: counts samples within a STAGE_L block and
// multiplies each by its twiddle, full precision, fixed 3-cycle latency.
module twiddle_mult
    import twiddle_mult_pkg::*;
#(
    parameter int  FFT_N   = 64,
    parameter int  STAGE_L = 64,
    parameter int  IN_W    = 16,
    parameter int  TW_W    = 16,
    localparam int OUT_W   = IN_W + TW_W
) (
    input  logic                    mclk,
    input  logic                    i_rst_n,
    input  logic                    i_init,
    input  logic                    i_vld,
    input  logic signed [IN_W-1:0]  i_re,
    input  logic signed [IN_W-1:0]  i_im,
    output logic                    o_vld,
    output logic signed [OUT_W-1:0] o_re,
    output logic signed [OUT_W-1:0] o_im
);

    localparam int CW     = $clog2(STAGE_L);
    localparam int AW     = $clog2(FFT_N / 2);
    localparam int HALF_L = STAGE_L / 2;
    localparam int STRIDE = tw_stride(FFT_N, STAGE_L);

    logic [CW-1:0]           cnt_d, cnt_q;
    logic [AW-1:0]           tw_addr;
    logic signed [TW_W-1:0]  wr, wi;
    logic                    vld1_d, vld1_q, vld2_d, vld2_q, vld3_d, vld3_q;
    logic signed [IN_W-1:0]  re1_d, re1_q, im1_d, im1_q;
    logic signed [OUT_W-1:0] prr_d, prr_q, pii_d, pii_q, pri_d, pri_q, pir_d, pir_q;
    logic signed [OUT_W-1:0] ore_d, ore_q, oim_d, oim_q;

    twiddle_rom #(
        .FFT_N (FFT_N),
        .TW_W  (TW_W)
    ) u_rom (
        .mclk   (mclk),
        .i_addr (tw_addr),
        .o_wr   (wr),
        .o_wi   (wi)
    );

    always_comb begin
        cnt_d   = cnt_q;
        tw_addr = '0;
        if (i_init)
            cnt_d = '0;
        else if (i_vld)
            cnt_d = cnt_q + CW'(1);

        // first half of the block uses W(0); second half steps by the stride
        if (cnt_q >= CW'(HALF_L))
            tw_addr = AW'((int'(cnt_q) - HALF_L) * STRIDE);

        vld1_d = i_vld & ~i_init;
        vld2_d = vld1_q & ~i_init;
        vld3_d = vld2_q & ~i_init;

        re1_d = i_re;
        im1_d = i_im;

        prr_d = OUT_W'(re1_q) * OUT_W'(wr);
        pii_d = OUT_W'(im1_q) * OUT_W'(wi);
        pri_d = OUT_W'(re1_q) * OUT_W'(wi);
        pir_d = OUT_W'(im1_q) * OUT_W'(wr);

        // outputs only move together with a rising o_vld, so they hold otherwise
        ore_d = ore_q;
        oim_d = oim_q;
        if (vld3_d) begin
            ore_d = prr_q - pii_q;
            oim_d = pri_q + pir_q;
        end
    end

    always_ff @(posedge mclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q  <= '0;
            vld1_q <= 1'b0;
            vld2_q <= 1'b0;
            vld3_q <= 1'b0;
            ore_q  <= '0;
            oim_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            vld1_q <= vld1_d;
            vld2_q <= vld2_d;
            vld3_q <= vld3_d;
            ore_q  <= ore_d;
            oim_q  <= oim_d;
        end
    end

    always_ff @(posedge mclk) begin
        re1_q <= re1_d;
        im1_q <= im1_d;
        prr_q <= prr_d;
        pii_q <= pii_d;
        pri_q <= pri_d;
        pir_q <= pir_d;
    end

    assign o_vld = vld3_q;
    assign o_re  = ore_q;
    assign o_im  = oim_q;

endmodule

// File: tb/tb_twiddle_mult.sv
// Bench for twiddle_mult at FFT_N=8, STAGE_L=8, IN_W=8, TW_W=8: table vectors,
// init/reset sequences and random traffic against a floating-point reference.
module tb_twiddle_mult;

    localparam int N  = 8;
    localparam int L  = 8;
    localparam int IW = 8;
    localparam int TW = 8;
    localparam int OW = IW + TW;
    localparam int HMAX = 8192;

    logic                 mclk = 1'b0;
    logic                 i_rst_n = 1'b0;
    logic                 i_init = 1'b0;
    logic                 i_vld = 1'b0;
    logic signed [IW-1:0] i_re = '0;
    logic signed [IW-1:0] i_im = '0;
    logic                 o_vld;
    logic signed [OW-1:0] o_re;
    logic signed [OW-1:0] o_im;

    always #5 mclk = ~mclk;

    twiddle_mult #(
        .FFT_N   (N),
        .STAGE_L (L),
        .IN_W    (IW),
        .TW_W    (TW)
    ) dut (
        .mclk    (mclk),
        .i_rst_n (i_rst_n),
        .i_init  (i_init),
        .i_vld   (i_vld),
        .i_re    (i_re),
        .i_im    (i_im),
        .o_vld   (o_vld),
        .o_re    (o_re),
        .o_im    (o_im)
    );

    typedef struct {
        int re;
        int im;
        int ere;
        int eim;
    } vec_t;

    vec_t tab [16];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mcnt  = 0;
    int last_re = 0;
    int last_im = 0;
    bit hv  [HMAX];
    int hre [HMAX];
    int him [HMAX];

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        else          return -$rtoi(-x + 0.5);
    endfunction

    function automatic void ref_prod(input int c, input int re, input int im,
                                     output int pr, output int pim);
        int  e;
        real a;
        int  wr, wi;
        e   = (c < L / 2) ? 0 : (c - L / 2) * (N / L);
        a   = 2.0 * 3.14159265358979323846 * real'(e) / real'(N);
        wr  = rnd($cos(a) * (2.0 ** (TW - 2)));
        wi  = rnd(-$sin(a) * (2.0 ** (TW - 2)));
        pr  = re * wr - im * wi;
        pim = re * wi + im * wr;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step(input int re, input int im, input bit vld, input bit init,
                        input bit use_tab, input int tre, input int tim);
        int pr, pim, idx;
        bit expv;
        i_re   = IW'(re);
        i_im   = IW'(im);
        i_vld  = vld;
        i_init = init;
        if (!i_rst_n || init) begin
            mcnt    = 0;
            hv[cyc] = 1'b0;
            if (cyc >= 1) hv[cyc-1] = 1'b0;
            if (cyc >= 2) hv[cyc-2] = 1'b0;
        end else if (vld) begin
            ref_prod(mcnt, re, im, pr, pim);
            hv[cyc]  = 1'b1;
            hre[cyc] = use_tab ? tre : pr;
            him[cyc] = use_tab ? tim : pim;
            mcnt     = (mcnt + 1) % L;
        end else begin
            hv[cyc] = 1'b0;
        end
        @(posedge mclk);
        #1;
        expv = 1'b0;
        idx  = cyc - 2;
        if (idx >= 0) expv = hv[idx];
        if (expv) begin
            last_re = hre[idx];
            last_im = him[idx];
        end
        chk("o_vld", int'(o_vld), int'(expv));
        chk("o_re", int'(o_re), last_re);
        chk("o_im", int'(o_im), last_im);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic send_tab(input int k);
        step(tab[k].re, tab[k].im, 1'b1, 1'b0, 1'b1, tab[k].ere, tab[k].eim);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) tab[k] = '{100, 0, 6400, 0};
        tab[5]  = '{100, 0, 4500, -4500};
        tab[6]  = '{100, 0, 0, -6400};
        tab[7]  = '{100, 0, -4500, -4500};
        tab[8]  = '{-128, 127, -8192, 8128};
        tab[9]  = '{1, 2, 64, 128};
        tab[10] = '{-5, 7, -320, 448};
        tab[11] = '{0, -1, 0, -64};
        tab[12] = '{127, 127, 8128, 8128};
        tab[13] = '{10, 20, 1350, 450};
        tab[14] = '{3, -2, -128, -192};
        tab[15] = '{-128, -128, 0, 11520};

        #3;
        chk("reset o_vld", int'(o_vld), 0);
        chk("reset o_re", int'(o_re), 0);
        chk("reset o_im", int'(o_im), 0);
        step(55, 66, 1'b1, 1'b0, 1'b0, 0, 0);
        step(55, 66, 1'b1, 1'b0, 1'b0, 0, 0);
        #2 i_rst_n = 1'b1;

        for (int k = 0; k < 16; k++) send_tab(k);
        idle(3);
        for (int k = 0; k < 16; k++) begin
            send_tab(k);
            idle(1);
        end
        idle(3);

        step(1, 1, 1'b1, 1'b0, 1'b0, 0, 0);
        step(2, 2, 1'b1, 1'b0, 1'b0, 0, 0);
        step(3, 3, 1'b1, 1'b0, 1'b0, 0, 0);
        step(5, 5, 1'b1, 1'b1, 1'b0, 0, 0);
        for (int k = 0; k < 8; k++) send_tab(k);
        idle(3);

        for (int k = 0; k < 5; k++) step(k * 9 - 20, 30 - k, 1'b1, 1'b0, 1'b0, 0, 0);
        #3 i_rst_n = 1'b0;
        last_re = 0;
        last_im = 0;
        #1;
        chk("async rst o_vld", int'(o_vld), 0);
        chk("async rst o_re", int'(o_re), 0);
        chk("async rst o_im", int'(o_im), 0);
        step(7, 7, 1'b1, 1'b0, 1'b0, 0, 0);
        step(7, 7, 1'b1, 1'b0, 1'b0, 0, 0);
        #2 i_rst_n = 1'b1;
        for (int k = 8; k < 16; k++) send_tab(k);
        idle(3);

        for (int k = 0; k < 3000; k++) begin
            step(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, 1'b0, 0, 0);
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
